// File: rtl/canvas_pkg.sv
// Shared types and defaults for the frame-buffer write controller.
package canvas_pkg;

  typedef enum logic [1:0] {
    OP_PAINT     = 2'b00,
    OP_CLEAR     = 2'b01,
    OP_SET_COLOR = 2'b10,
    OP_SET_SIZE  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StPaint,
    StClear
  } state_e;

  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

  localparam logic [2:0] BRUSH_COLOR_RST = 3'b101;

endpackage

// File: rtl/rect_scanner.sv
// Walks a rectangle in raster order (y outer, x inner), one pixel per step.
module rect_scanner #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] ld_x0,
  input  logic [YW-1:0] ld_y0,
  input  logic [XW-1:0] ld_x1,
  input  logic [YW-1:0] ld_y1,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last,
  output logic          next_last
);

  logic [XW-1:0] x_q, x0_q, x1_q, nx;
  logic [YW-1:0] y_q, y1_q, ny;
  logic          eol;

  always_comb begin
    eol       = (x_q == x1_q);
    nx        = eol ? x0_q : x_q + XW'(1);
    ny        = eol ? y_q + YW'(1) : y_q;
    last      = eol && (y_q == y1_q);
    // Lets the controller leave its busy state as the final pixel is presented.
    next_last = (nx == x1_q) && (ny == y1_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
    end else if (load) begin
      x_q  <= ld_x0;
      y_q  <= ld_y0;
      x0_q <= ld_x0;
      x1_q <= ld_x1;
      y1_q <= ld_y1;
    end else if (step) begin
      x_q <= nx;
      y_q <= ny;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/canvas_write_ctrl.sv
// Turns drawing commands into one-pixel-per-cycle writes for the pixel store.
module canvas_write_ctrl
  import canvas_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF,
  parameter int unsigned XW    = 10,
  parameter int unsigned YW    = 10,
  parameter int unsigned CW    = 3,
  parameter int unsigned SW    = 3,
  parameter int unsigned AW    = (CW > SW) ? CW : SW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [AW-1:0] cmd_arg,
  output logic          wr_en,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [CW-1:0] wr_color,
  output logic          busy
);

  localparam logic [XW-1:0] XMAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] YMAX = YW'(V_RES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] brush_color_q, brush_color_d;
  logic [SW-1:0] brush_size_q, brush_size_d;
  logic          wr_en_q, wr_en_d;
  logic [CW-1:0] wr_color_q, wr_color_d;

  logic          load, step, on_screen;
  logic [XW-1:0] ld_x0, ld_x1, clip_x0, clip_x1;
  logic [YW-1:0] ld_y0, ld_y1, clip_y0, clip_y1;
  logic          scan_last, scan_next_last;

  logic signed [XW:0] px_lo, px_hi;
  logic signed [YW:0] py_lo, py_hi;

  // Signed one-bit-wider arithmetic so the low edge can go negative before clipping.
  always_comb begin
    px_lo   = $signed({1'b0, cmd_x}) - $signed({{(XW + 1 - SW){1'b0}}, brush_size_q});
    px_hi   = $signed({1'b0, cmd_x}) + $signed({{(XW + 1 - SW){1'b0}}, brush_size_q});
    py_lo   = $signed({1'b0, cmd_y}) - $signed({{(YW + 1 - SW){1'b0}}, brush_size_q});
    py_hi   = $signed({1'b0, cmd_y}) + $signed({{(YW + 1 - SW){1'b0}}, brush_size_q});
    clip_x0 = px_lo[XW] ? '0 : px_lo[XW-1:0];
    clip_y0 = py_lo[YW] ? '0 : py_lo[YW-1:0];
    clip_x1 = (px_hi > $signed({1'b0, XMAX})) ? XMAX : px_hi[XW-1:0];
    clip_y1 = (py_hi > $signed({1'b0, YMAX})) ? YMAX : py_hi[YW-1:0];
    on_screen = (cmd_x <= XMAX) && (cmd_y <= YMAX);
  end

  always_comb begin
    state_d       = state_q;
    brush_color_d = brush_color_q;
    brush_size_d  = brush_size_q;
    wr_en_d       = 1'b0;
    wr_color_d    = wr_color_q;
    load          = 1'b0;
    step          = 1'b0;
    ld_x0         = '0;
    ld_y0         = '0;
    ld_x1         = XMAX;
    ld_y1         = YMAX;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_SET_COLOR: brush_color_d = cmd_arg[CW-1:0];
            OP_SET_SIZE:  brush_size_d  = cmd_arg[SW-1:0];
            OP_PAINT: begin
              if (on_screen) begin
                load       = 1'b1;
                ld_x0      = clip_x0;
                ld_y0      = clip_y0;
                ld_x1      = clip_x1;
                ld_y1      = clip_y1;
                wr_en_d    = 1'b1;
                wr_color_d = brush_color_q;
                if (!((clip_x0 == clip_x1) && (clip_y0 == clip_y1))) state_d = StPaint;
              end
            end
            OP_CLEAR: begin
              load       = 1'b1;
              wr_en_d    = 1'b1;
              wr_color_d = cmd_arg[CW-1:0];
              if ((XMAX != '0) || (YMAX != '0)) state_d = StClear;
            end
          endcase
        end
      end
      StPaint, StClear: begin
        step    = 1'b1;
        wr_en_d = 1'b1;
        if (scan_next_last || scan_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      brush_color_q <= CW'(BRUSH_COLOR_RST);
      brush_size_q  <= '0;
      wr_en_q       <= 1'b0;
      wr_color_q    <= '0;
    end else begin
      state_q       <= state_d;
      brush_color_q <= brush_color_d;
      brush_size_q  <= brush_size_d;
      wr_en_q       <= wr_en_d;
      wr_color_q    <= wr_color_d;
    end
  end

  rect_scanner #(
    .XW(XW),
    .YW(YW)
  ) u_scanner (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .step     (step),
    .ld_x0    (ld_x0),
    .ld_y0    (ld_y0),
    .ld_x1    (ld_x1),
    .ld_y1    (ld_y1),
    .x        (wr_x),
    .y        (wr_y),
    .last     (scan_last),
    .next_last(scan_next_last)
  );

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign wr_en     = wr_en_q;
  assign wr_color  = wr_color_q;

endmodule

// File: tb/tb_canvas_write_ctrl.sv
// Scoreboard bench: a rectangle model predicts every write and its cycle; a monitor checks them.
module tb_canvas_write_ctrl;

  localparam int H = 40;
  localparam int V = 30;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [9:0] cmd_x = '0;
  logic [9:0] cmd_y = '0;
  logic [2:0] cmd_arg = '0;
  logic       wr_en;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic [2:0] wr_color;
  logic       busy;

  canvas_write_ctrl #(
    .H_RES(H),
    .V_RES(V)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_x    (cmd_x),
    .cmd_y    (cmd_y),
    .cmd_arg  (cmd_arg),
    .wr_en    (wr_en),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_color (wr_color),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_writes = 0;
  int   ready_from = 0;
  int   m_color = 5;
  int   m_size = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: compare ready/busy every cycle and every presented write against the queue head.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      check("cmd_ready", int'(cmd_ready), int'(cyc >= ready_from));
      check("busy_vs_ready", int'(busy), int'(!cmd_ready));
      if (wr_en) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_x", int'(wr_x), e.x);
          check("wr_y", int'(wr_y), e.y);
          check("wr_color", int'(wr_color), e.c);
          check("wr_cycle", cyc, e.t);
        end
      end else if (exp_q.size() != 0 && exp_q[0].t <= cyc) begin
        check("missing_write", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // Reference model, invoked just after the accepting edge (cyc == accept edge).
  task automatic model_accept(input int op, input int x, input int y, input int arg);
    int x0, x1, y0, y1, k, c;
    if (op == 2) begin
      m_color = arg & 7;
    end else if (op == 3) begin
      m_size = arg & 7;
    end else if (op == 0 && (x >= H || y >= V)) begin
      // accepted and dropped
    end else begin
      if (op == 0) begin
        x0 = (x - m_size < 0) ? 0 : x - m_size;
        x1 = (x + m_size > H - 1) ? H - 1 : x + m_size;
        y0 = (y - m_size < 0) ? 0 : y - m_size;
        y1 = (y + m_size > V - 1) ? V - 1 : y + m_size;
        c  = m_color;
      end else begin
        x0 = 0;
        y0 = 0;
        x1 = H - 1;
        y1 = V - 1;
        c  = arg & 7;
      end
      k = 0;
      for (int yy = y0; yy <= y1; yy++) begin
        for (int xx = x0; xx <= x1; xx++) begin
          exp_q.push_back('{x: xx, y: yy, c: c, t: cyc + k});
          k++;
        end
      end
      ready_from = cyc + k - 1;
    end
  endtask

  // Called at posedge+#1; holds cmd_valid until the DUT shows ready, leaves it low on return.
  task automatic send(input int op, input int x, input int y, input int arg);
    bit got;
    int waited;
    got       = 1'b0;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_x     = 10'(x);
    cmd_y     = 10'(y);
    cmd_arg   = 3'(arg);
    while (!got && waited < 4000) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      cmd_valid = 1'b0;
      check("accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      model_accept(op, x, y, arg);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base, w, r;
    idle(3);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_x", int'(wr_x), 0);
    check("rst_wr_y", int'(wr_y), 0);
    check("rst_wr_color", int'(wr_color), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    idle(2);

    send(0, 10, 20, 0);                 // single dot, reset colour 5
    idle(2);
    send(3, 0, 0, 2);
    send(2, 0, 0, 3);
    send(0, 0, 0, 0);                   // clipped corner: 9 writes
    idle(12);
    send(3, 0, 0, 7);
    send(0, H - 1, V - 1, 0);           // 8x8 at far corner
    send(3, 0, 0, 1);
    send(0, 10, 10, 0);                 // back-to-back 3x3 pair
    send(0, 20, 5, 0);
    send(0, H + 5, 10, 0);              // off-screen, dropped
    send(0, 3, V, 0);                   // off-screen in y, dropped
    send(1, 0, 0, 6);                   // CLEAR
    send(2, 0, 0, 1);                   // held while busy, must wait
    send(0, 1, 1, 0);
    idle(20);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5 || r == 9) send(0, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 0);
      else if (r == 6) send(3, 0, 0, $urandom_range(0, 7));
      else if (r == 7) send(2, 0, 0, $urandom_range(0, 7));
      else send(0, $urandom_range(H, H + 30), $urandom_range(0, V + 10), 0);
      idle($urandom_range(0, 2));
    end

    // CLEAR interrupted by reset
    idle(80);
    base = n_writes;
    send(1, 0, 0, 2);
    w = 0;
    while (n_writes < base + 200 && w < 2000) begin
      idle(1);
      w++;
    end
    check("clear_progress", int'(n_writes >= base + 200), 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_wr_en", int'(wr_en), 0);
    check("async_rst_ready", int'(cmd_ready), 1);
    exp_q.delete();
    m_color    = 5;
    m_size     = 0;
    ready_from = 0;
    idle(2);
    reset_n = 1'b1;
    idle(2);
    send(0, 5, 7, 0);                   // brush back to colour 5, size 0
    send(0, 39, 0, 0);

    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      idle(1);
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/canvas_write_ctrl.md
# canvas_write_ctrl

Write-side controller for the pixel store frame buffer. Accepts decoded drawing commands (paint dot, clear screen, set brush colour, set brush size) through a valid/ready handshake. It sequences them into one-pixel-per-cycle writes on the pixel store write port (wx, wy, newColor, write enable). Sits between the SPI command decoder and the pixel store; the VGA read side is untouched.

## Interface
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- XW, 10, x coordinate width
- YW, 10, y coordinate width
- CW, 3, colour code width
- SW, 3, brush size width (radius 0..2^SW-1)

- clk  in  1  pixel clock. One clock; every flop is on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  command: 00 PAINT, 01 CLEAR, 10 SET_COLOR, 11 SET_SIZE
- cmd_x  in  XW  PAINT centre x
- cmd_y  in  YW  PAINT centre y
- cmd_arg  in  max(CW,SW)  colour for CLEAR/SET_COLOR; size for SET_SIZE (low SW bits)
- wr_en  out  1  pixel write strobe
- wr_x  out  XW  write x
- wr_y  out  YW  write y
- wr_color  out  CW  write colour
- busy  out  1  PAINT or CLEAR in progress (equals ~cmd_ready)

## Operation
- **Handshake.** A command transfers on a rising edge with cmd_valid & cmd_ready. cmd_x, cmd_y, cmd_op and cmd_arg are sampled only then.
- **FSM states.** IDLE, PAINT, CLEAR. cmd_ready = (state == IDLE).
- **SET_COLOR.** Latches cmd_arg[CW-1:0] into brush_color. State stays IDLE; cmd_ready stays 1. No writes.
- **SET_SIZE.** Latches cmd_arg[SW-1:0] into brush_size. State stays IDLE; cmd_ready stays 1. No writes.
- **PAINT, clipped rectangle.** Writes brush_color over the square centred on (cmd_x, cmd_y) with side 2*brush_size+1, clipped to the screen:
  - x0 = max(cx-s, 0), x1 = min(cx+s, H_RES-1)
  - y0 = max(cy-s, 0), y1 = min(cy+s, V_RES-1)
  - Clip arithmetic uses XW+1 / YW+1 bit signed values.
  - Raster order: y outer, x inner; one pixel per cycle.
- **PAINT, off-screen centre.** If cx >= H_RES or cy >= V_RES, the command is accepted and dropped. No writes; state stays IDLE.
- **PAINT, colour/size snapshot.** brush_color and brush_size are sampled at accept. The next SET_* cannot arrive before PAINT completes.
- **CLEAR.** Writes cmd_arg[CW-1:0] to every pixel (0,0)..(H_RES-1,V_RES-1) in raster order: H_RES*V_RES writes. brush_color is unchanged.
- **Return to IDLE.** Both PAINT and CLEAR return to IDLE in the same cycle the last write is presented.

## Timing
- **Reset values:**
  - state IDLE, cmd_ready 1, busy 0
  - wr_en 0, wr_x 0, wr_y 0, wr_color 0
  - brush_color 3'b101, brush_size 0
- **Registered outputs.** All wr_* outputs are registered.
- **PAINT/CLEAR timing.** For a command accepted at edge t:
  - First wr_en is high in cycle t+1.
  - A command of N pixels drives wr_en high for cycles t+1..t+N with no gaps.
  - cmd_ready is low in cycles t+1..t+N-1 and high again in cycle t+N.
- **Back-to-back commands.** A new command may be accepted at edge t+N, giving zero bubble between commands.
- **No-write commands.** SET_* and dropped PAINT accepted at t: wr_en stays 0 and cmd_ready stays 1.
- **Counter wrap.** The x counter wraps x1 -> x0 with y+1. Termination is on (x == x1 && y == y1). No wrap past the rectangle.
- **Reset mid-operation.** reset_n low forces IDLE and wr_en 0 immediately (asynchronous). Remaining pixels are abandoned; brush registers return to reset values.
- **cmd_valid while busy.** Ignored; the upstream holds the command until cmd_ready is seen.

## Structure
- **Package canvas_pkg** holds:
  - the cmd_op enum (OP_PAINT, OP_CLEAR, OP_SET_COLOR, OP_SET_SIZE) and FSM state enum
  - H_RES/V_RES defaults
  - reset brush colour constant
- **Sub-module rect_scanner.** Load (x0, y0, x1, y1), step one pixel per cycle, output current (x, y) plus a last flag. Shared by PAINT and CLEAR; CLEAR loads (0, 0, H_RES-1, V_RES-1).
- **Top-level logic.** Clip arithmetic, brush registers and FSM live in canvas_write_ctrl.

## Test plan
- After reset: wr_en 0, cmd_ready 1, brush_color 5. PAINT (10,20), size 0 -> exactly one write at (10,20), colour 5, in cycle t+1; cmd_ready high in t+1.
- SET_SIZE 2, SET_COLOR 3, PAINT (0,0) -> 9 writes, (0,0),(1,0),(2,0),(0,1)..(2,2), colour 3. Corner clipped, no negative coordinates.
- SET_SIZE 7, PAINT (639,479) -> 64 writes, x 632..639, y 472..479, last (639,479).
- Two PAINTs back-to-back (size 1 at (100,100), then (200,50)) with cmd_valid held -> 18 consecutive writes, no idle cycle between them.
- CLEAR colour 0 -> 307200 consecutive writes, first (0,0), last (639,479). cmd_ready low until the final write cycle; cmd_valid asserted meanwhile is not accepted.
- PAINT (700,10) -> accepted, zero writes. Then CLEAR with reset_n pulsed low after 1000 writes -> wr_en 0 at once, cmd_ready 1 after release, brush_color back to 5.
